// File: rtl/k2_prog_loader.sv
// Writable 16x8 instruction store for the K2 CPU, loaded from a framed byte
// stream (SYNC, LEN, data..., CSUM) while the CPU is held in reset.
module k2_prog_loader #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] address,
  output logic [7:0] instruction,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err,
  output logic [4:0] loaded_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [4:0] count;
  logic [4:0] len;
  logic [7:0] sum;
  logic       accept;

  // Gated by reset so the host sees no ready while the loader is held.
  assign in_ready    = reset && (state != S_DONE) && (state != S_ERR);
  assign accept      = in_valid && in_ready;
  assign instruction = mem[address];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      count      <= 5'd0;
      len        <= 5'd0;
      sum        <= 8'h00;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      loaded_len <= 5'd0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && in_data == SYNC) begin
            state    <= S_LEN;
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            count    <= 5'd0;
            sum      <= 8'h00;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (in_data != 8'h00 && in_data <= DEPTH_B) begin
              len   <= in_data[4:0];
              state <= S_DATA;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          // SYNC bytes here are plain data; the frame length alone ends this phase.
          if (accept) begin
            mem[count[3:0]] <= in_data;
            count           <= count + 5'd1;
            sum             <= sum + in_data;
            if (count == len - 5'd1) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == sum) begin
              state      <= S_DONE;
              load_done  <= 1'b1;
              loaded_len <= len;
              cpu_hold   <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
